// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - five-stage pipeline stall/flush sequencer with stall watchdog
// Optional stall-cycle performance counter enabled by `define PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
    parameter int REFILL_CYC = 3,
    parameter int STALL_MAX  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        excp_valid,
    input  logic [31:0] excp_pc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic        pc_load,
    output logic [31:0] new_pc,
    output logic        stall_timeout
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    localparam logic [3:0]  RF_LOAD = REFILL_CYC[3:0];
    localparam logic [15:0] WD_MAX  = STALL_MAX[15:0];

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        REFILL = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [3:0]  refill_cnt, refill_nx;
    logic [15:0] wd_cnt, wd_nx;
    logic        accept;

    // The deepest requesting stage freezes itself and everything upstream of it.
    always_comb begin
        stall = 6'b000000;
        if (state != FLUSH) begin
            if (stallreq_mem)      stall = 6'b011111;
            else if (stallreq_ex)  stall = 6'b001111;
            else if (stallreq_id)  stall = 6'b000111;
            else if (stallreq_if)  stall = 6'b000011;
        end
    end

    always_comb begin
        state_nx  = state;
        refill_nx = refill_cnt;
        accept    = 1'b0;
        case (state)
            RUN: begin
                if (excp_valid) begin
                    accept   = 1'b1;
                    state_nx = FLUSH;
                end
            end
            FLUSH: begin
                refill_nx = RF_LOAD;
                state_nx  = (RF_LOAD == 4'd0) ? RUN : REFILL;
            end
            REFILL: begin
                refill_nx = refill_cnt - 4'd1;
                if (refill_cnt <= 4'd1) state_nx = RUN;
            end
            default: state_nx = RUN;
        endcase
    end

    always_comb begin
        wd_nx = wd_cnt;
        if (state == FLUSH || !stall[0])
            wd_nx = 16'd0;
        else if (wd_cnt != WD_MAX)
            wd_nx = wd_cnt + 16'd1;
    end

    assign flush   = (state == FLUSH);
    assign pc_load = (state == FLUSH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= RUN;
            refill_cnt    <= 4'd0;
            wd_cnt        <= 16'd0;
            new_pc        <= 32'h0;
            stall_timeout <= 1'b0;
        end else begin
            state      <= state_nx;
            refill_cnt <= refill_nx;
            wd_cnt     <= wd_nx;
            if (accept)
                new_pc <= excp_pc;
            if (wd_nx == WD_MAX)
                stall_timeout <= 1'b1;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            perf_cnt <= 32'h0;
        else if (stall[0])
            perf_cnt <= perf_cnt + 32'd1;
    end

    assign stall_cycles = perf_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl with REFILL_CYC=3, STALL_MAX=4
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stallreq_if = 1'b0, stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
    logic        excp_valid = 1'b0;
    logic [31:0] excp_pc = 32'h0;
    logic [5:0]  stall;
    logic        flush, pc_load, stall_timeout;
    logic [31:0] new_pc;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles;
`endif

    pipe_ctrl #(.REFILL_CYC(3), .STALL_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .excp_valid(excp_valid), .excp_pc(excp_pc),
        .stall(stall), .flush(flush), .pc_load(pc_load),
        .new_pc(new_pc), .stall_timeout(stall_timeout)
`ifdef PIPE_CTRL_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  stall;
        logic        fl;
        logic [31:0] pc;
        logic        to;
        logic [31:0] perf;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc_no = 0;
    logic [31:0] perf_model = 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc_no, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        cyc_no++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall", {26'h0, stall}, {26'h0, e.stall});
            chk("flush", {31'h0, flush}, {31'h0, e.fl});
            chk("pc_load", {31'h0, pc_load}, {31'h0, e.fl});
            chk("new_pc", new_pc, e.pc);
            chk("stall_timeout", {31'h0, stall_timeout}, {31'h0, e.to});
`ifdef PIPE_CTRL_PERF_EN
            chk("stall_cycles", stall_cycles, e.perf);
`endif
        end
    end

    // req = {mem, ex, id, if}; expectations describe the cycle being driven
    task automatic cyc(input logic [3:0] req, input logic ev, input logic [31:0] epc,
                       input logic [5:0] e_stall, input logic e_fl, input logic [31:0] e_pc,
                       input logic e_to);
        exp_t e;
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req;
        excp_valid = ev;
        excp_pc    = epc;
        e.stall = e_stall;
        e.fl    = e_fl;
        e.pc    = e_pc;
        e.to    = e_to;
        e.perf  = perf_model;
        exp_q.push_back(e);
        if (e_stall[0]) perf_model = perf_model + 32'd1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL deadline: bench did not finish, queue depth %0d expected 0", exp_q.size());
        $fatal(1, "deadline");
    end

    initial begin
        @(posedge clk);
        #1;
        cyc(4'b0000, 0, 32'h0, 6'b000000, 0, 32'h0, 0);
        rst = 1'b1;

        // priority encoding
        cyc(4'b0111, 0, 32'h0, 6'b001111, 0, 32'h0, 0);
        cyc(4'b1111, 0, 32'h0, 6'b011111, 0, 32'h0, 0);
        cyc(4'b0010, 0, 32'h0, 6'b000111, 0, 32'h0, 0);
        cyc(4'b0000, 0, 32'h0, 6'b000000, 0, 32'h0, 0);
        cyc(4'b0001, 0, 32'h0, 6'b000011, 0, 32'h0, 0);
        cyc(4'b0000, 0, 32'h0, 6'b000000, 0, 32'h0, 0);

        // exception at N with coincident stall, masked retries in FLUSH and REFILL
        cyc(4'b0100, 1, 32'h20, 6'b001111, 0, 32'h0,  0);
        cyc(4'b1000, 1, 32'h40, 6'b000000, 1, 32'h20, 0);
        cyc(4'b0000, 1, 32'h40, 6'b000000, 0, 32'h20, 0);
        cyc(4'b0000, 0, 32'h0,  6'b000000, 0, 32'h20, 0);
        cyc(4'b0001, 1, 32'h40, 6'b000011, 0, 32'h20, 0);
        cyc(4'b0000, 1, 32'h60, 6'b000000, 0, 32'h20, 0);
        cyc(4'b0000, 0, 32'h0,  6'b000000, 1, 32'h60, 0);
        repeat (4) cyc(4'b0000, 0, 32'h0, 6'b000000, 0, 32'h60, 0);

        // reset asserted in the middle of the FLUSH cycle
        cyc(4'b0000, 1, 32'h80, 6'b000000, 0, 32'h60, 0);
        #1;
        rst = 1'b0;
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'b0000;
        excp_valid = 1'b0;
        perf_model = 32'h0;
        exp_q.push_back('{6'b000000, 1'b0, 32'h0, 1'b0, 32'h0});
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(4'b0000, 0, 32'h0,  6'b000000, 0, 32'h0,  0);
        cyc(4'b0000, 1, 32'ha0, 6'b000000, 0, 32'h0,  0);
        cyc(4'b0000, 0, 32'h0,  6'b000000, 1, 32'ha0, 0);
        repeat (3) cyc(4'b0000, 0, 32'h0, 6'b000000, 0, 32'ha0, 0);

        // ten stalled cycles among twenty
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) cyc(4'b0001, 0, 32'h0, 6'b000011, 0, 32'ha0, 0);
            else            cyc(4'b0000, 0, 32'h0, 6'b000000, 0, 32'ha0, 0);
        end

`ifdef PIPE_CTRL_PERF_EN
        cyc(4'b0000, 0, 32'h0, 6'b000000, 0, 32'ha0, 0);
        force dut.perf_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.perf_cnt;
        perf_model = 32'hFFFF_FFFE;
        cyc(4'b0001, 0, 32'h0, 6'b000011, 0, 32'ha0, 0);
        cyc(4'b0001, 0, 32'h0, 6'b000011, 0, 32'ha0, 0);
        cyc(4'b0000, 0, 32'h0, 6'b000000, 0, 32'ha0, 0);
`endif

        // watchdog: runs of three broken by a gap never trip it
        repeat (3) cyc(4'b0100, 0, 32'h0, 6'b001111, 0, 32'ha0, 0);
        cyc(4'b0000, 0, 32'h0, 6'b000000, 0, 32'ha0, 0);
        repeat (3) cyc(4'b0100, 0, 32'h0, 6'b001111, 0, 32'ha0, 0);
        cyc(4'b0000, 0, 32'h0, 6'b000000, 0, 32'ha0, 0);

        // four consecutive stalls trip it, and it stays set
        repeat (4) cyc(4'b0100, 0, 32'h0, 6'b001111, 0, 32'ha0, 0);
        cyc(4'b0000, 0, 32'h0, 6'b000000, 0, 32'ha0, 1);
        cyc(4'b0000, 0, 32'h0, 6'b000000, 0, 32'ha0, 1);

        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
